// File: rtl/bicubic_pkg.sv
// Shared types and widths for the bicubic resize sequencer.
package bicubic_pkg;
  localparam int IMG_W_DEF = 100;
  localparam int POS_W     = 5;
  localparam int FRAC_W    = 6;
  localparam int CNT_W     = 6;

  typedef enum logic [2:0] {IDLE, CALC, FETCH, WAIT, WRITE, FIN} state_t;
endpackage

// File: rtl/bicubic_dda.sv
// Division-free DDA: accumulates step, wraps at den and bumps the integer position.
module bicubic_dda
  import bicubic_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [FRAC_W-1:0] step,
  input  logic [FRAC_W-1:0] den,
  input  logic              advance,
  input  logic              clear,
  output logic [POS_W-1:0]  int_pos,
  output logic [FRAC_W-1:0] frac
);
  logic [FRAC_W:0] sum;

  assign sum = {1'b0, frac} + {1'b0, step};

  // step <= den, so a single subtraction always brings the accumulator back below den
  always_ff @(posedge CLK) begin
    if (!RST || clear) begin
      int_pos <= '0;
      frac    <= '0;
    end else if (advance) begin
      if (sum >= {1'b0, den}) begin
        frac    <= FRAC_W'(sum - {1'b0, den});
        int_pos <= int_pos + POS_W'(1);
      end else begin
        frac <= sum[FRAC_W-1:0];
      end
    end
  end
endmodule

// File: rtl/bicubic_ctrl.sv
// Bicubic resize sequencer: raster walk over target pixels, 4x4 ROM fetch, result write-back.
module bicubic_ctrl
  import bicubic_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int ROM_AW = 14,
  parameter int RAM_AW = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [6:0]        V0,
  input  logic [6:0]        H0,
  input  logic [4:0]        SW,
  input  logic [4:0]        SH,
  input  logic [5:0]        TW,
  input  logic [5:0]        TH,
  output logic [ROM_AW-1:0] rom_a,
  input  logic [7:0]        rom_q,
  output logic [7:0]        dp_pix,
  output logic              dp_pix_vld,
  output logic              dp_first,
  output logic [5:0]        dp_fx,
  output logic [5:0]        dp_fy,
  output logic [5:0]        dp_den_x,
  output logic [5:0]        dp_den_y,
  input  logic [7:0]        dp_res,
  input  logic              dp_res_vld,
  output logic [RAM_AW-1:0] sram_a,
  output logic [7:0]        sram_d,
  output logic              sram_wen,
  output logic              DONE
);
  state_t            state, state_nxt;
  logic [6:0]        v0_q, h0_q;
  logic [POS_W-1:0]  sw_m1_q, sh_m1_q;
  logic [CNT_W-1:0]  tw_m1_q, th_m1_q;
  logic [CNT_W-1:0]  tx, ty;
  logic [3:0]        k, k_idx;
  logic [RAM_AW-1:0] wr_addr;
  logic [POS_W-1:0]  x_int, y_int;
  logic [7:0]        nb_col, nb_row;
  logic [ROM_AW-1:0] rom_a_nxt;
  logic              cfg_ok, last_col, last_pix;
  logic              adv_x, adv_y, clr_x, clr_y;

  // Neighbour coordinate: origin + clamp(pos + idx - 1, 0, lim)
  function automatic logic [7:0] clamp_coord(input logic [6:0] origin,
                                             input logic [POS_W-1:0] pos,
                                             input logic [1:0] idx,
                                             input logic [POS_W-1:0] lim);
    logic signed [7:0] off;
    off = signed'({3'b000, pos}) + signed'({6'b000000, idx}) - 8'sd1;
    if (off[7])
      off = '0;
    else if (off > signed'({3'b000, lim}))
      off = signed'({3'b000, lim});
    return {1'b0, origin} + off;
  endfunction

  assign cfg_ok   = (SW >= 5'd2) && ({1'b0, SW} <= TW) && (SH >= 5'd2) && ({1'b0, SH} <= TH);
  assign last_col = (tx == tw_m1_q);
  assign last_pix = last_col && (ty == th_m1_q);

  // Address for the tap presented next cycle: tap 0 from CALC, tap k+1 from FETCH
  assign k_idx     = (state == FETCH) ? k + 4'd1 : 4'd0;
  assign nb_col    = clamp_coord(h0_q, x_int, k_idx[1:0], sw_m1_q);
  assign nb_row    = clamp_coord(v0_q, y_int, k_idx[3:2], sh_m1_q);
  assign rom_a_nxt = ROM_AW'(int'(nb_row) * IMG_W + int'(nb_col));

  bicubic_dda u_dda_x (
    .CLK(CLK), .RST(RST), .step({1'b0, sw_m1_q}), .den(tw_m1_q),
    .advance(adv_x), .clear(clr_x), .int_pos(x_int), .frac(dp_fx)
  );

  bicubic_dda u_dda_y (
    .CLK(CLK), .RST(RST), .step({1'b0, sh_m1_q}), .den(th_m1_q),
    .advance(adv_y), .clear(clr_y), .int_pos(y_int), .frac(dp_fy)
  );

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    adv_x     = 1'b0;
    adv_y     = 1'b0;
    clr_x     = (state == IDLE);
    clr_y     = (state == IDLE);
    case (state)
      IDLE:  state_nxt = cfg_ok ? CALC : FIN;
      CALC:  state_nxt = FETCH;
      FETCH: if (k == 4'd15) state_nxt = WAIT;
      WAIT:  if (dp_res_vld) state_nxt = WRITE;
      WRITE: begin
        if (last_pix) begin
          state_nxt = FIN;
        end else begin
          state_nxt = CALC;
          if (last_col) begin
            clr_x = 1'b1;
            adv_y = 1'b1;
          end else begin
            adv_x = 1'b1;
          end
        end
      end
      FIN:     state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      v0_q <= '0; h0_q <= '0; sw_m1_q <= '0; sh_m1_q <= '0;
      tw_m1_q <= '0; th_m1_q <= '0;
      tx <= '0; ty <= '0; k <= '0; wr_addr <= '0;
      rom_a <= '0; dp_pix_vld <= 1'b0; dp_first <= 1'b0;
      sram_a <= '0; sram_d <= '0; sram_wen <= 1'b0;
    end else begin
      // ROM data for tap k lands one cycle after its address
      dp_pix_vld <= (state == FETCH);
      dp_first   <= (state == FETCH) && (k == 4'd0);
      sram_wen   <= (state == WAIT) && dp_res_vld;
      case (state)
        IDLE: begin
          v0_q    <= V0;
          h0_q    <= H0;
          sw_m1_q <= SW - 5'd1;
          sh_m1_q <= SH - 5'd1;
          tw_m1_q <= TW - 6'd1;
          th_m1_q <= TH - 6'd1;
          tx      <= '0;
          ty      <= '0;
          wr_addr <= '0;
        end
        CALC: begin
          rom_a <= rom_a_nxt;
          k     <= '0;
        end
        FETCH: begin
          if (k != 4'd15) rom_a <= rom_a_nxt;
          k <= k + 4'd1;
        end
        WAIT: begin
          if (dp_res_vld) begin
            sram_a <= wr_addr;
            sram_d <= dp_res;
          end
        end
        WRITE: begin
          wr_addr <= wr_addr + RAM_AW'(1);
          if (!last_pix) begin
            if (last_col) begin
              tx <= '0;
              ty <= ty + CNT_W'(1);
            end else begin
              tx <= tx + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dp_pix   = dp_pix_vld ? rom_q : 8'd0;
  assign dp_den_x = tw_m1_q;
  assign dp_den_y = th_m1_q;
  assign DONE     = (state == FIN);
endmodule

// File: tb/tb_bicubic_ctrl.sv
// Scoreboard bench for bicubic_ctrl: ROM and datapath models, randomized jobs.
module tb_bicubic_ctrl;
  logic        CLK, RST;
  logic [6:0]  V0, H0;
  logic [4:0]  SW, SH;
  logic [5:0]  TW, TH;
  logic [13:0] rom_a;
  logic [7:0]  rom_q;
  logic [7:0]  dp_pix;
  logic        dp_pix_vld, dp_first;
  logic [5:0]  dp_fx, dp_fy, dp_den_x, dp_den_y;
  logic [7:0]  dp_res;
  logic        dp_res_vld;
  logic [11:0] sram_a;
  logic [7:0]  sram_d;
  logic        sram_wen, DONE;

  bicubic_ctrl #(.IMG_W(100), .ROM_AW(14), .RAM_AW(12)) dut (
    .CLK(CLK), .RST(RST), .V0(V0), .H0(H0), .SW(SW), .SH(SH), .TW(TW), .TH(TH),
    .rom_a(rom_a), .rom_q(rom_q), .dp_pix(dp_pix), .dp_pix_vld(dp_pix_vld),
    .dp_first(dp_first), .dp_fx(dp_fx), .dp_fy(dp_fy), .dp_den_x(dp_den_x),
    .dp_den_y(dp_den_y), .dp_res(dp_res), .dp_res_vld(dp_res_vld),
    .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen), .DONE(DONE)
  );

  typedef struct {int addr; bit first; int fx; int fy; int denx; int deny;} pix_t;
  typedef struct {int data; int cyc;} wd_t;

  pix_t        exp_pix[$];
  int          exp_wa[$];
  wd_t         exp_wd[$];
  logic [7:0]  rom_mem [0:16383];
  logic [13:0] rom_a_d;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int last_wr_cyc = -100;
  int res_delay = 0;
  bit spur_en = 0;

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) begin
    cyc     <= cyc + 1;
    rom_q   <= rom_mem[rom_a];
    rom_a_d <= rom_a;
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Reference: exact rational source position per target pixel, clamped 4x4 window
  task automatic build_model(input int v0, input int h0, input int sw, input int sh,
                             input int tw, input int th);
    for (int ty = 0; ty < th; ty++) begin
      for (int tx = 0; tx < tw; tx++) begin
        int xi, fx, yi, fy;
        xi = (tx * (sw - 1)) / (tw - 1);
        fx = (tx * (sw - 1)) % (tw - 1);
        yi = (ty * (sh - 1)) / (th - 1);
        fy = (ty * (sh - 1)) % (th - 1);
        for (int dy = -1; dy <= 2; dy++) begin
          for (int dx = -1; dx <= 2; dx++) begin
            pix_t p;
            p.addr  = clampi(v0 + yi + dy, v0, v0 + sh - 1) * 100
                    + clampi(h0 + xi + dx, h0, h0 + sw - 1);
            p.first = (dy == -1) && (dx == -1);
            p.fx    = fx;
            p.fy    = fy;
            p.denx  = tw - 1;
            p.deny  = th - 1;
            exp_pix.push_back(p);
          end
        end
        exp_wa.push_back(ty * tw + tx);
      end
    end
  endtask

  task automatic flush();
    exp_pix.delete();
    exp_wa.delete();
    exp_wd.delete();
  endtask

  task automatic check_reset_zero(input string name);
    longint s;
    s = longint'(rom_a) + dp_pix + dp_pix_vld + dp_first + dp_fx + dp_fy + dp_den_x
      + dp_den_y + sram_a + sram_d + sram_wen + DONE;
    chk(name, s, 0);
  endtask

  // Datapath model: answers each 16-pixel burst after res_delay cycles
  initial begin : responder
    int  cnt, wait_left;
    bit  pending;
    logic [13:0] frozen;
    cnt = 0; wait_left = 0; pending = 0; frozen = '0;
    dp_res_vld = 0;
    dp_res = 0;
    forever begin
      @(negedge CLK);
      dp_res_vld = 0;
      if (!RST) begin
        cnt = 0;
        pending = 0;
      end else begin
        if (pending) begin
          chk("stall_rom_a", rom_a, frozen);
          chk("stall_wen", sram_wen, 0);
          if (wait_left == 0) begin
            dp_res_vld = 1;
            dp_res = 8'($urandom_range(0, 255));
            exp_wd.push_back('{int'(dp_res), cyc});
            pending = 0;
          end else begin
            wait_left--;
          end
        end
        if (spur_en && dp_first) begin
          dp_res_vld = 1;
          dp_res = 8'($urandom_range(0, 255));
        end
        if (dp_pix_vld) begin
          cnt++;
          if (cnt == 16) begin
            cnt = 0;
            frozen = rom_a;
            if (res_delay == 0) begin
              dp_res_vld = 1;
              dp_res = 8'($urandom_range(0, 255));
              exp_wd.push_back('{int'(dp_res), cyc});
            end else begin
              pending = 1;
              wait_left = res_delay - 1;
            end
          end
        end
      end
    end
  end

  always @(negedge CLK) begin : monitor
    pix_t p;
    wd_t  w;
    int   ea;
    if (RST) begin
      if (dp_pix_vld) begin
        if (exp_pix.size() > 0) p = exp_pix.pop_front();
        else p = '{-1, 1'b0, -1, -1, -1, -1};
        chk("rom_addr", rom_a_d, p.addr);
        chk("dp_pix", dp_pix, (p.addr >= 0) ? int'(rom_mem[p.addr]) : -1);
        chk("dp_first", dp_first, p.first);
        if (p.first) begin
          chk("dp_fx", dp_fx, p.fx);
          chk("dp_fy", dp_fy, p.fy);
          chk("dp_den_x", dp_den_x, p.denx);
          chk("dp_den_y", dp_den_y, p.deny);
        end
      end
      if (sram_wen) begin
        wr_count++;
        last_wr_cyc = cyc;
        ea = (exp_wa.size() > 0) ? exp_wa.pop_front() : -1;
        if (exp_wd.size() > 0) w = exp_wd.pop_front();
        else w = '{-1, -10};
        chk("sram_a", sram_a, ea);
        chk("sram_d", sram_d, w.data);
        chk("write_latency", cyc, w.cyc + 1);
      end
    end
  end

  task automatic run_job(input int v0, input int h0, input int sw, input int sh,
                         input int tw, input int th, input int dly, input bit spur,
                         input int abort_at);
    bit legal, aborted;
    int n, budget, done_cyc, nwr;
    legal = (sw >= 2) && (sw <= tw) && (sh >= 2) && (sh <= th);
    nwr = legal ? tw * th : 0;
    @(negedge CLK);
    RST = 0;
    V0 = 7'(v0); H0 = 7'(h0); SW = 5'(sw); SH = 5'(sh); TW = 6'(tw); TH = 6'(th);
    res_delay = dly;
    spur_en = spur;
    flush();
    repeat (2) @(negedge CLK);
    check_reset_zero("reset_outputs");
    RST = 1;
    wr_count = 0;
    last_wr_cyc = -100;
    aborted = 0;
    if (legal) build_model(v0, h0, sw, sh, tw, th);
    budget = tw * th * (30 + dly) + 50;
    n = 0;
    while (n < budget && !DONE) begin
      @(negedge CLK);
      n++;
      if (!aborted && abort_at >= 0 && wr_count == abort_at && dp_pix_vld) begin
        RST = 0;
        flush();
        @(negedge CLK);
        check_reset_zero("midjob_reset");
        RST = 1;
        wr_count = 0;
        last_wr_cyc = -100;
        aborted = 1;
        n = 0;
        if (legal) build_model(v0, h0, sw, sh, tw, th);
      end
    end
    done_cyc = cyc;
    chk("done_timeout", DONE, 1);
    if (legal) begin
      chk("done_after_last_write", done_cyc, last_wr_cyc + 1);
      chk("pix_left", exp_pix.size(), 0);
      chk("wr_left", exp_wa.size(), 0);
    end else begin
      chk("illegal_done_within_2", (n <= 2) ? 1 : 0, 1);
    end
    chk("write_count", wr_count, nwr);
    repeat (3) @(negedge CLK);
    chk("done_hold", DONE, 1);
    chk("no_write_after_done", wr_count, nwr);
  endtask

  initial begin : stim
    int tw, th, sw, sh;
    RST = 0;
    V0 = 0; H0 = 0; SW = 0; SH = 0; TW = 0; TH = 0;
    for (int i = 0; i < 16384; i++) rom_mem[i] = 8'($urandom_range(0, 255));

    run_job(10, 10, 4, 4, 4, 4, 0, 0, -1);   // identity
    run_job(20, 30, 3, 2, 5, 2, 1, 0, -1);   // upscale x
    run_job(96, 96, 4, 4, 4, 4, 0, 0, -1);   // bottom-right clamp
    run_job(5, 7, 3, 3, 4, 4, 20, 1, -1);    // stalled datapath, spurious result
    run_job(50, 20, 3, 3, 4, 4, 2, 0, 5);    // reset during pixel 5 fetch
    run_job(10, 10, 2, 2, 1, 4, 0, 0, -1);   // illegal TW=1
    run_job(0, 0, 2, 3, 6, 5, 0, 0, -1);     // top-left clamp, upscale both
    for (int j = 0; j < 5; j++) begin
      tw = $urandom_range(2, 8);
      th = $urandom_range(2, 8);
      sw = $urandom_range(2, tw);
      sh = $urandom_range(2, th);
      run_job($urandom_range(0, 100 - sh), $urandom_range(0, 100 - sw), sw, sh, tw, th,
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
    end
    tw = $urandom_range(2, 7);
    run_job(3, 4, tw + 1, 2, tw, 4, 0, 0, -1); // illegal SW>TW

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bicubic_ctrl.md
Name: bicubic_ctrl

Overview:
- Sequencer for the Bicubic resize engine. Latches the window and target configuration, then walks target pixels in raster order.
- Per target pixel it:
  - computes the source integer position and fraction with DDA counters (no divider);
  - fetches the 4x4 neighbourhood from ImgROM and streams it to the interpolation datapath;
  - writes the datapath result to ResultSRAM.
- Raises DONE after the last write.

Parameters:
IMG_W, 100, ImgROM row pitch in pixels
ROM_AW, 14, ImgROM address width
RAM_AW, 12, ResultSRAM address width

Ports:
CLK  input  1  clock
RST  input  1  reset, synchronous, active-low
V0  input  7  source window top row
H0  input  7  source window left column
SW  input  5  source width
SH  input  5  source height
TW  input  6  target width
TH  input  6  target height
rom_a  output  ROM_AW  ImgROM address
rom_q  input  8  ImgROM data, one cycle after rom_a
dp_pix  output  8  neighbourhood pixel to datapath
dp_pix_vld  output  1  dp_pix valid
dp_first  output  1  marks pixel 0 of 16
dp_fx  output  6  x fraction numerator
dp_fy  output  6  y fraction numerator
dp_den_x  output  6  TW-1
dp_den_y  output  6  TH-1
dp_res  input  8  interpolated result
dp_res_vld  input  1  result valid, single-cycle pulse
sram_a  output  RAM_AW  ResultSRAM address
sram_d  output  8  write data
sram_wen  output  1  write enable, active-high
DONE  output  1  job complete

Behaviour:
- Reset
  - RST low at any CLK edge, including mid-job: next state IDLE.
  - All outputs reset to 0: rom_a, dp_*, sram_*, DONE. Counters are cleared.
- Configuration
  - Latched in IDLE on the first cycle RST is high.
  - Legal configuration: 2<=SW<=TW, 2<=SH<=TH.
  - Illegal configuration: go to FIN directly, with zero SRAM writes and DONE one cycle later.
- DDA, x direction (y is identical with SH/TH/ty)
  - Per tx step: acc_x += SW-1.
  - If acc_x >= TW-1: subtract TW-1 and increment x_int. At most one wrap per step because SW<=TW.
  - At tx=0: acc_x=0, x_int=0. Row wrap resets acc_x and x_int, then steps the y DDA.
  - dp_fx=acc_x, dp_fy=acc_y, held stable from CALC until WRITE.
- Neighbour coordinates
  - col = clamp(H0+x_int+dx, H0, H0+SW-1), for dx = -1..2.
  - row = clamp(V0+y_int+dy, V0, V0+SH-1), for dy = -1..2.
  - Fetch order: dy outer, dx inner.
  - rom_a = row*IMG_W + col, 14-bit unsigned, no overflow since row, col <= 99.
- FSM
  - IDLE -> CALC.
  - CALC (1 cycle): compute base coordinates -> FETCH.
  - FETCH (16 cycles): issue rom_a with k=0..15. dp_pix_vld on cycles k+1 carries rom_q; dp_first with k=0. Then -> WAIT.
  - WAIT: hold until dp_res_vld. No timeout. dp_res_vld outside WAIT is ignored.
  - WRITE (1 cycle): sram_wen=1, sram_a=ty*TW+tx, sram_d=dp_res.
    - If last pixel (tx=TW-1, ty=TH-1): -> FIN.
    - Otherwise advance the DDA -> CALC.
  - FIN: DONE=1, held until RST low.
- Minimum per-pixel latency: 1+16+1+1 = 19 cycles plus datapath delay.
- sram_wen is only ever high in WRITE, exactly one pulse per target pixel. Addresses are strictly increasing from 0 to TW*TH-1.

Decomposition:
- Package bicubic_pkg holds:
  - FSM state enum: IDLE, CALC, FETCH, WAIT, WRITE, FIN.
  - IMG_W constant.
  - Coordinate/fraction widths.
- Sub-module bicubic_dda, instanced twice (x, y).
  - Inputs: step, den, advance, clear.
  - Outputs: int_pos, frac.

Test Plan:
1. Identity: H0=V0=10, SW=SH=TW=TH=4.
   - First pixel rom_a = 1010,1010,1011,1012, 1010,1010,1011,1012, 1110,...
   - 16 writes, sram_a 0..15; DONE after 16th write.
2. Upscale x: SW=3, TW=5, SH=TH=2.
   - Per row, (x_int, dp_fx) = (0,0),(0,2),(1,0),(1,2),(2,0); dp_den_x=4.
3. Corner clamp: H0=V0=96, SW=SH=TW=TH=4.
   - Last pixel columns 98,99,99,99; final rom_a=9999.
   - No address exceeds 9999 or falls below 9696.
4. Stall: dp_res_vld delayed 20 cycles.
   - rom_a frozen, sram_wen=0 throughout; write occurs the cycle after the pulse.
   - A spurious dp_res_vld during FETCH causes no write.
5. Reset mid-FETCH of pixel 5: RST low one cycle.
   - All outputs 0 next cycle.
   - After release, the first write has sram_a=0 and fraction/position restart at 0.
6. Illegal TW=1: DONE=1 within 2 cycles of reset release, zero sram_wen pulses.
